m_epp_fifo_bridge: RTL and testbench
====================================

// Module: m_epp_fifo_bridge
// PURPOSE
//  Next-generation PC link for midgetv on EPP-style parallel boards. Bridges the
//  host-side EPP port (address/data strobes, nWAIT handshake) to a midgetv
//  Wishbone-like slave. Adds a FIFO per direction and runs entirely in CLK_I;
//  pads go through synchronisers.
//  Adds an overrun flag, FIFO fill levels and a 2-bit EPP register address.
// PARAMETERS
//  TXAW   4  log2 depth of tx FIFO (midgetv -> PC), 2^TXAW bytes
//  RXAW   4  log2 depth of rx FIFO (PC -> midgetv), 2^RXAW bytes
//  NSYNC  2  synchroniser flops on padnADDRSTB/padnDATASTB/padnWRITE (>=2)
// PORTS
//  CLK_I        in   1  system clock (only clock)
//  nRST_I       in   1  reset, synchronous, active low
//  DAT_I        in   8  write data from midgetv
//  ADR_I        in   2  midgetv register select
//  STB_I        in   1  access strobe
//  WE_I         in   1  1 = write cycle
//  DAT_O        out  8  read data to midgetv
//  ACK_O        out  1  = STB_I (single-cycle access)
//  padnADDRSTB  in   1  EPP address strobe, active low
//  padnDATASTB  in   1  EPP data strobe, active low
//  padnWRITE    in   1  EPP write, active low
//  padDB        inout 8 EPP address/data bus
//  padnWAIT     out  1  EPP handshake: 0 = may start cycle, 1 = may end cycle
// BEHAVIOUR
//  Reset (nRST_I=0 at CLK_I edge): both FIFOs empty, overrun=0, eppadr=0, EPP FSM
//   IDLE, padnWAIT=0, padDB released (8'bz). Applies mid-transfer: cycle abandoned.
//  Status byte STAT = {tx_level_is_zero, 3'b0, ovr, txfull, rxnempty, txnfull}:
//   bit0 txnfull (midgetv may write), bit1 rxnempty (byte for midgetv),
//   bit2 txfull (PC-side tx data pending when !tx_empty is bit7), bit3 ovr
//   (sticky: PC wrote to full rx FIFO), bit7 tx FIFO empty.
//  midgetv map (ACK_O=STB_I; write/pop on the single STB_I cycle, registered):
//   ADR 0 rd: DAT_O = rx head; pop if !empty; empty -> DAT_O=8'h00, no pop.
//   ADR 0 wr: push DAT_I to tx FIFO; full -> write dropped, no state change.
//   ADR 1 rd: STAT.  ADR 1 wr: DAT_I[3]=1 clears ovr.
//   ADR 2 rd: rx fill count (zero-extended).  ADR 3 rd: tx fill count.
//   Writes to ADR 2/3 ignored. DAT_O combinational from ADR_I and FIFO heads.
//  EPP side: strobes/nWRITE synchronised (NSYNC flops); padDB sampled by one
//   flop on the strobe-assert detection cycle (host holds it stable). FSM:
//   IDLE: padnWAIT=0. Synced strobe low -> ACT (only one strobe honoured; both
//    low -> address strobe wins).
//   ACT (1 cycle): address write: eppadr<=padDB[1:0]. Data write: eppadr 0 ->
//    push rx (full -> drop, ovr<=1); eppadr 1 -> DB[3]=1 clears ovr; 2,3 ignored.
//    Data read: drive padDB = sel(eppadr): 0 tx head, 1 STAT, 2 rx count,
//    3 tx count; tx empty on adr 0 -> 8'h00. Address read: drive {6'b0,eppadr}.
//    -> HOLD, padnWAIT=1.
//   HOLD: padnWAIT=1, read data held. Synced strobe high -> IDLE; tx pop on
//    this transition if data read at eppadr 0 and tx non-empty.
//   padDB driven only while nWRITE synced high, in ACT/HOLD.
//  Latency: strobe edge -> padnWAIT=1 in NSYNC+2 cycles; PC write visible to
//   midgetv rxnempty NSYNC+2 cycles after strobe fall.
//  FIFOs: RAM + pointers one bit wider than address; wrap natural mod 2^AW;
//   count width AW+1, saturates at 2^AW (full). Push+pop same cycle on a
//   non-empty FIFO: count unchanged; on empty FIFO: push only. Pop on a full
//   FIFO concurrent with push: both succeed. midgetv push and PC pop on tx in
//   same cycle allowed; likewise rx.
// TESTING
//  Reset mid-HOLD: nRST_I=0 one cycle -> padnWAIT=0, padDB=z, counts 0, ovr=0.
//  PC addr-write 0, data-writes 8'hA5,8'h3C -> midgetv ADR2 reads 2; ADR0 reads
//   A5 then 3C; ADR1 bit1=0 after.
//  midgetv writes 2^TXAW+1 bytes 0..16 (TXAW=4) -> 17th dropped; PC reads
//   0..15, 17th PC read returns 8'h00, STAT bit7=1.
//  PC writes 17 bytes with RXAW=4 -> ovr=1 (STAT bit3); midgetv ADR1 write 8'h08
//   -> ovr=0; rx count stays 16.
//  Simultaneous midgetv push and PC pop on tx with count=16 -> count 16, order kept.
//  Both strobes asserted together with DB=8'h01 -> eppadr=1, rx count unchanged.

Source files
------------

// File: rtl/m_epp_fifo_bridge.sv
// rtl/m_epp_fifo_bridge.sv - EPP host port to midgetv slave bridge with a byte FIFO per direction
// Pads are synchronised into CLK_I; the EPP handshake is a three-state FSM.

module m_epp_fifo_bridge_fifo #(
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    din_i,
    output logic [7:0]    dout_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [7:0]  mem_q [2**AW];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

module m_epp_fifo_bridge #(
    parameter int TXAW  = 4,
    parameter int RXAW  = 4,
    parameter int NSYNC = 2
) (
    input  logic       CLK_I,
    input  logic       nRST_I,
    input  logic [7:0] DAT_I,
    input  logic [1:0] ADR_I,
    input  logic       STB_I,
    input  logic       WE_I,
    output logic [7:0] DAT_O,
    output logic       ACK_O,
    input  logic       padnADDRSTB,
    input  logic       padnDATASTB,
    input  logic       padnWRITE,
    inout  wire  [7:0] padDB,
    output logic       padnWAIT
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACT, ST_HOLD} state_t;

    state_t       state_q, state_d;
    logic [NSYNC-1:0] astb_sync_q, dstb_sync_q, nwr_sync_q;
    logic         astb_s, dstb_s, nwr_s;
    logic         is_addr_q, is_addr_d;
    logic         is_wr_q, is_wr_d;
    logic [1:0]   db_adr_q, db_adr_d;
    logic         db_clr_q, db_clr_d;
    logic [1:0]   eppadr_q, eppadr_d;
    logic [7:0]   rd_q, rd_d;
    logic         ovr_q, ovr_d;

    logic         start, strobe_rel;
    logic         epp_rx_push, epp_tx_pop, epp_ovr_clr, db_oe;
    logic         mg_tx_push, mg_rx_pop, mg_ovr_clr;
    logic [7:0]   epp_rd_val, db_out, stat;

    logic [7:0]   tx_head, rx_head;
    logic [TXAW:0] tx_count;
    logic [RXAW:0] rx_count;
    logic         tx_full, tx_empty, rx_full, rx_empty;

    m_epp_fifo_bridge_fifo #(.AW(TXAW)) u_tx_fifo (
        .clk_i   (CLK_I),
        .nrst_i  (nRST_I),
        .push_i  (mg_tx_push),
        .pop_i   (epp_tx_pop),
        .din_i   (DAT_I),
        .dout_o  (tx_head),
        .count_o (tx_count),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    m_epp_fifo_bridge_fifo #(.AW(RXAW)) u_rx_fifo (
        .clk_i   (CLK_I),
        .nrst_i  (nRST_I),
        .push_i  (epp_rx_push),
        .pop_i   (mg_rx_pop),
        .din_i   (padDB),
        .dout_o  (rx_head),
        .count_o (rx_count),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // Synchronisers reset to the inactive level so a strobe held across reset is not re-honoured at once.
    always_ff @(posedge CLK_I) begin
        if (!nRST_I) begin
            astb_sync_q <= '1;
            dstb_sync_q <= '1;
            nwr_sync_q  <= '1;
        end else begin
            astb_sync_q <= {astb_sync_q[NSYNC-2:0], padnADDRSTB};
            dstb_sync_q <= {dstb_sync_q[NSYNC-2:0], padnDATASTB};
            nwr_sync_q  <= {nwr_sync_q[NSYNC-2:0], padnWRITE};
        end
    end

    assign astb_s     = astb_sync_q[NSYNC-1];
    assign dstb_s     = dstb_sync_q[NSYNC-1];
    assign nwr_s      = nwr_sync_q[NSYNC-1];
    assign start      = !astb_s || !dstb_s;
    assign strobe_rel = is_addr_q ? astb_s : dstb_s;

    assign stat = {tx_empty, 3'b000, ovr_q, tx_full, !rx_empty, !tx_full};

    always_comb begin
        epp_rd_val = 8'h00;
        if (is_addr_q) begin
            epp_rd_val = {6'b000000, eppadr_q};
        end else begin
            case (eppadr_q)
                2'd0:    epp_rd_val = tx_empty ? 8'h00 : tx_head;
                2'd1:    epp_rd_val = stat;
                2'd2:    epp_rd_val = 8'(rx_count);
                default: epp_rd_val = 8'(tx_count);
            endcase
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!nRST_I) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_ACT;
            ST_ACT:  state_d = ST_HOLD;
            ST_HOLD: if (strobe_rel) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        padnWAIT    = (state_q == ST_HOLD);
        db_oe       = (state_q != ST_IDLE) && nwr_s;
        db_out      = (state_q == ST_HOLD) ? rd_q : epp_rd_val;
        epp_rx_push = (state_q == ST_ACT) && !is_addr_q && is_wr_q && (eppadr_q == 2'd0);
        epp_ovr_clr = (state_q == ST_ACT) && !is_addr_q && is_wr_q && (eppadr_q == 2'd1) && db_clr_q;
        epp_tx_pop  = (state_q == ST_HOLD) && strobe_rel && !is_addr_q && !is_wr_q && (eppadr_q == 2'd0);
    end

    assign padDB = db_oe ? db_out : 8'bz;

    // Cycle attributes and the bus are captured once, on the cycle the strobe is first seen.
    always_comb begin
        is_addr_d = is_addr_q;
        is_wr_d   = is_wr_q;
        db_adr_d  = db_adr_q;
        db_clr_d  = db_clr_q;
        eppadr_d  = eppadr_q;
        rd_d      = rd_q;
        if (state_q == ST_IDLE && start) begin
            is_addr_d = !astb_s;
            is_wr_d   = !nwr_s;
            db_adr_d  = padDB[1:0];
            db_clr_d  = padDB[3];
        end
        if (state_q == ST_ACT) begin
            rd_d = epp_rd_val;
            if (is_addr_q && is_wr_q) eppadr_d = db_adr_q;
        end
    end

    assign mg_tx_push = STB_I && WE_I && (ADR_I == 2'd0);
    assign mg_rx_pop  = STB_I && !WE_I && (ADR_I == 2'd0);
    assign mg_ovr_clr = STB_I && WE_I && (ADR_I == 2'd1) && DAT_I[3];

    // A host write to a full rx FIFO is an overrun unless midgetv frees a slot that same cycle.
    always_comb begin
        ovr_d = ovr_q;
        if (mg_ovr_clr || epp_ovr_clr) ovr_d = 1'b0;
        if (epp_rx_push && rx_full && !mg_rx_pop) ovr_d = 1'b1;
    end

    always_ff @(posedge CLK_I) begin
        if (!nRST_I) begin
            is_addr_q <= 1'b0;
            is_wr_q   <= 1'b0;
            db_adr_q  <= 2'd0;
            db_clr_q  <= 1'b0;
            eppadr_q  <= 2'd0;
            rd_q      <= 8'h00;
            ovr_q     <= 1'b0;
        end else begin
            is_addr_q <= is_addr_d;
            is_wr_q   <= is_wr_d;
            db_adr_q  <= db_adr_d;
            db_clr_q  <= db_clr_d;
            eppadr_q  <= eppadr_d;
            rd_q      <= rd_d;
            ovr_q     <= ovr_d;
        end
    end

    assign ACK_O = STB_I;

    always_comb begin
        DAT_O = 8'h00;
        case (ADR_I)
            2'd0:    DAT_O = rx_empty ? 8'h00 : rx_head;
            2'd1:    DAT_O = stat;
            2'd2:    DAT_O = 8'(rx_count);
            default: DAT_O = 8'(tx_count);
        endcase
    end
endmodule

// File: tb/tb_m_epp_fifo_bridge.sv
// tb/tb_m_epp_fifo_bridge.sv - scoreboard bench for m_epp_fifo_bridge
// Stimulus tasks queue expected bytes; monitors compare on midgetv reads and EPP read handshakes.

module tb_m_epp_fifo_bridge;
    logic       CLK_I = 1'b0;
    logic       nRST_I = 1'b0;
    logic [7:0] DAT_I = 8'h00;
    logic [1:0] ADR_I = 2'd0;
    logic       STB_I = 1'b0;
    logic       WE_I = 1'b0;
    wire  [7:0] DAT_O;
    wire        ACK_O;
    logic       padnADDRSTB = 1'b1;
    logic       padnDATASTB = 1'b1;
    logic       padnWRITE = 1'b1;
    wire  [7:0] padDB;
    wire        padnWAIT;
    logic [7:0] tb_db = 8'h00;
    logic       tb_oe = 1'b0;

    assign padDB = tb_oe ? tb_db : 8'bz;

    m_epp_fifo_bridge #(.TXAW(4), .RXAW(4), .NSYNC(2)) dut (
        .CLK_I       (CLK_I),
        .nRST_I      (nRST_I),
        .DAT_I       (DAT_I),
        .ADR_I       (ADR_I),
        .STB_I       (STB_I),
        .WE_I        (WE_I),
        .DAT_O       (DAT_O),
        .ACK_O       (ACK_O),
        .padnADDRSTB (padnADDRSTB),
        .padnDATASTB (padnDATASTB),
        .padnWRITE   (padnWRITE),
        .padDB       (padDB),
        .padnWAIT    (padnWAIT)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct {
        logic [7:0] v;
        string      name;
    } exp_t;

    exp_t mg_q[$];
    exp_t epp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic epp_rd = 1'b0;
    logic wait_prev = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %02h required %02h", name, act, req);
        end
    endtask

    always @(negedge CLK_I) begin
        exp_t e;
        if (nRST_I && STB_I && !WE_I) begin
            if (!ACK_O) begin
                checks++;
                errors++;
                $display("FAIL mg_ack: got 0 required 1");
            end
            if (mg_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mg_unexpected: got read %02h required none", DAT_O);
            end else begin
                e = mg_q.pop_front();
                chk(e.name, DAT_O, e.v);
            end
        end
    end

    always @(negedge CLK_I) begin
        exp_t e;
        if (padnWAIT && !wait_prev && epp_rd) begin
            if (epp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL epp_unexpected: got read %02h required none", padDB);
            end else begin
                e = epp_q.pop_front();
                chk(e.name, padDB, e.v);
            end
        end
        wait_prev = padnWAIT;
    end

    task automatic mg_wr(input logic [1:0] a, input logic [7:0] d);
        @(posedge CLK_I); #1;
        STB_I = 1'b1; WE_I = 1'b1; ADR_I = a; DAT_I = d;
        @(posedge CLK_I); #1;
        STB_I = 1'b0; WE_I = 1'b0;
    endtask

    task automatic mg_rd(input logic [1:0] a, input logic [7:0] exp, input string name);
        mg_q.push_back('{exp, name});
        @(posedge CLK_I); #1;
        STB_I = 1'b1; WE_I = 1'b0; ADR_I = a;
        @(posedge CLK_I); #1;
        STB_I = 1'b0;
    endtask

    task automatic wait_nwait(input logic lvl, input string name);
        int n;
        n = 0;
        while (padnWAIT !== lvl && n < 30) begin
            @(posedge CLK_I); #1;
            n++;
        end
        if (padnWAIT !== lvl) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got padnWAIT %b required %b", name, padnWAIT, lvl);
        end
    endtask

    // mode 0: plain cycle; 1: midgetv tx push of pd lands on the host pop cycle; 2: reset while in HOLD
    task automatic epp(input logic an, input logic dn, input logic wn, input logic [7:0] d,
                       input logic [7:0] exp, input string name, input int mode, input logic [7:0] pd);
        @(posedge CLK_I); #1;
        if (!wn) begin
            tb_db = d;
            tb_oe = 1'b1;
        end else begin
            epp_q.push_back('{exp, name});
            epp_rd = 1'b1;
        end
        padnWRITE = wn; padnADDRSTB = an; padnDATASTB = dn;
        wait_nwait(1'b1, name);
        if (mode == 2) begin
            @(posedge CLK_I); #1;
            nRST_I = 1'b0;
            @(posedge CLK_I); #1;
            nRST_I = 1'b1;
            padnADDRSTB = 1'b1; padnDATASTB = 1'b1; padnWRITE = 1'b1; tb_oe = 1'b0;
            chk("rst_mid_hold_nwait", {7'b0, padnWAIT}, 8'h00);
        end else begin
            padnADDRSTB = 1'b1; padnDATASTB = 1'b1;
            if (mode == 1) begin
                @(posedge CLK_I);
                @(posedge CLK_I); #1;
                STB_I = 1'b1; WE_I = 1'b1; ADR_I = 2'd0; DAT_I = pd;
                @(posedge CLK_I); #1;
                STB_I = 1'b0; WE_I = 1'b0;
            end
            wait_nwait(1'b0, name);
        end
        padnWRITE = 1'b1;
        tb_oe = 1'b0;
        epp_rd = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge CLK_I);
        #1 nRST_I = 1'b1;
        chk("rst_nwait", {7'b0, padnWAIT}, 8'h00);
        mg_rd(2'd1, 8'h81, "rst_stat");
        mg_rd(2'd2, 8'h00, "rst_rx_cnt");
        mg_rd(2'd3, 8'h00, "rst_tx_cnt");
        mg_rd(2'd0, 8'h00, "rst_rx_empty_read");

        epp(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, "aw0", 0, 8'h00);
        epp(1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, "dw_a5", 0, 8'h00);
        epp(1'b1, 1'b0, 1'b0, 8'h3C, 8'h00, "dw_3c", 0, 8'h00);
        mg_rd(2'd2, 8'h02, "rx_cnt_2");
        mg_rd(2'd1, 8'h83, "stat_rxnempty");
        mg_rd(2'd0, 8'hA5, "rx_first");
        mg_rd(2'd0, 8'h3C, "rx_second");
        mg_rd(2'd1, 8'h81, "stat_rx_drained");
        epp(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, "ar_eppadr0", 0, 8'h00);

        for (int i = 0; i < 17; i++) mg_wr(2'd0, 8'(i));
        mg_rd(2'd3, 8'h10, "tx_cnt_16");
        mg_rd(2'd1, 8'h04, "stat_txfull");
        for (int i = 0; i < 16; i++) epp(1'b1, 1'b0, 1'b1, 8'h00, 8'(i), "tx_pc_read", 0, 8'h00);
        epp(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, "tx_read_empty", 0, 8'h00);
        mg_rd(2'd3, 8'h00, "tx_cnt_0");
        epp(1'b0, 1'b1, 1'b0, 8'h01, 8'h00, "aw1", 0, 8'h00);
        epp(1'b1, 1'b0, 1'b1, 8'h00, 8'h81, "epp_stat_tx_empty", 0, 8'h00);

        epp(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, "aw0_b", 0, 8'h00);
        for (int i = 0; i < 16; i++) mg_wr(2'd0, 8'(8'h20 + i));
        epp(1'b1, 1'b0, 1'b1, 8'h00, 8'h20, "tx_conc_pop", 1, 8'h30);
        mg_rd(2'd3, 8'h10, "tx_cnt_conc");
        for (int i = 1; i <= 16; i++) epp(1'b1, 1'b0, 1'b1, 8'h00, 8'(8'h20 + i), "tx_order", 0, 8'h00);

        for (int i = 0; i < 17; i++) epp(1'b1, 1'b0, 1'b0, 8'(8'h40 + i), 8'h00, "rx_fill", 0, 8'h00);
        mg_rd(2'd1, 8'h8B, "stat_ovr");
        mg_rd(2'd2, 8'h10, "rx_cnt_sat");
        mg_wr(2'd1, 8'h08);
        mg_rd(2'd1, 8'h83, "stat_ovr_cleared");
        mg_rd(2'd2, 8'h10, "rx_cnt_after_clr");
        mg_rd(2'd0, 8'h40, "rx_head_after_ovr");

        epp(1'b0, 1'b0, 1'b0, 8'h01, 8'h00, "both_strobes", 0, 8'h00);
        mg_rd(2'd2, 8'h0F, "rx_cnt_both");
        epp(1'b0, 1'b1, 1'b1, 8'h00, 8'h01, "ar_eppadr1", 0, 8'h00);

        epp(1'b1, 1'b0, 1'b1, 8'h00, 8'h83, "rd_before_rst", 2, 8'h00);
        mg_rd(2'd2, 8'h00, "rst_mid_rx_cnt");
        mg_rd(2'd3, 8'h00, "rst_mid_tx_cnt");
        mg_rd(2'd1, 8'h81, "rst_mid_stat");
        epp(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, "ar_after_rst", 0, 8'h00);

        repeat (5) @(posedge CLK_I);
        chk("mg_queue_drained", 8'(mg_q.size()), 8'h00);
        chk("epp_queue_drained", 8'(epp_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
